wb_host_master: RTL and testbench
=================================

Name: wb_host_master

Overview:
- Single-outstanding Wishbone pipelined-mode initiator, and the bus-owning counterpart of the team's Wishbone slave peripherals (e.g. the 0x3000_0000 register block).
- Converts a simple valid/ready command port (from test firmware, a CPU shim or a bench driver) into one bus read or write.
- Honours stall, waits for ack, bounds each transfer with a timeout.
- Returns read data plus an error flag on a one-cycle response strobe.

Parameters:
- ADDR_W, 32, address width of the command port and the bus.
- DATA_W, 32, data width of the command port and the bus.
- TIMEOUT_CYCLES, 255, maximum cycles from stb assertion to ack; 0 disables the timeout.
- TO_W, 8, timeout counter width; TIMEOUT_CYCLES must fit in it.

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  1  command present
- req_ready  output  1  block can accept a command (IDLE only)
- req_we  input  1  1=write, 0=read
- req_addr  input  ADDR_W  byte address
- req_wdata  input  DATA_W  write data
- resp_valid  output  1  one-cycle pulse; transfer finished
- resp_rdata  output  DATA_W  read data (0 for writes and errors)
- resp_err  output  1  transfer timed out
- o_wb_cyc  output  1  bus cycle
- o_wb_stb  output  1  strobe
- o_wb_we  output  1  write enable
- o_wb_addr  output  ADDR_W  address
- o_wb_data  output  DATA_W  write data
- i_wb_ack  input  1  slave completion
- i_wb_stall  input  1  slave cannot accept stb
- i_wb_data  input  DATA_W  read data

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset state: all outputs registered and 0, except req_ready=1; FSM in IDLE; timeout counter 0.
- FSM states: IDLE, REQ, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid, latch we/addr/wdata onto o_wb_*, set cyc=stb=1, clear counter, go REQ.
  - REQ: cyc=stb=1, outputs held stable.
    - If !i_wb_stall, drop stb (cyc stays 1) and go WAIT.
    - If i_wb_ack && !i_wb_stall in the same cycle, complete directly (zero-wait slave).
  - WAIT: cyc=1, stb=0. On i_wb_ack, capture i_wb_data (reads only), drop cyc, go RESP.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE; req_ready returns to 1 the next cycle.
- Ack handling: ack while in REQ with stall=1 is a slave protocol violation; ignore it. Ack in IDLE or RESP is ignored.
- Latency: command accepted at edge T; stb visible in cycle T+1. With a stall-free slave acking one cycle after stb, ack is in T+2 and resp_valid is in T+3. Minimum command-to-command spacing is 4 cycles.
- Timeout (TIMEOUT_CYCLES>0):
  - Counter increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES-1 with no ack that cycle, drop cyc and stb and go RESP with resp_err=1, resp_rdata=0.
  - Ack arriving in that same cycle wins: normal completion, err=0.
  - The counter saturates and never wraps.
- resp_rdata: held until the next RESP. Writes return 0.
- req_valid outside IDLE: ignored; the command is not consumed (req_ready=0).
- Reset mid-transfer: cyc and stb drop immediately (asynchronous). No response is generated.

Decomposition:
- Shared package wb_pkg holds:
  - FSM state enum (IDLE, REQ, WAIT, RESP)
  - default TIMEOUT_CYCLES
  - the peripheral address map (BASE 0x3000_0000, +4 result register), shared with the slaves and benches
- Sub-module wb_timeout_ctr: saturating counter with clear/enable inputs and an expired flag. Everything else is inline.

Test Plan:
- Write, stall-free slave: req we=1 addr=0x3000_0000 wdata=0x0000_0503 -> stb for 1 cycle with o_wb_data=0x0000_0503; resp_valid at T+3; err=0; rdata=0.
- Read back: req we=0 addr=0x3000_0004; slave returns 0x0000_0008 -> resp_rdata=0x0000_0008, err=0, resp_valid one cycle only.
- Stall: slave holds stall=1 for 3 cycles -> stb and addr stable for 4 cycles; stb drops the cycle after stall clears; ack is then accepted normally.
- Timeout: TIMEOUT_CYCLES=8, slave never acks -> cyc drops after 8 cycles of cyc; resp_err=1, rdata=0; next command accepted the cycle after resp_valid.
- Boundary ack: ack arrives exactly in the expiry cycle -> err=0, data captured. Separately, a stray ack in IDLE -> no resp_valid.
- Reset mid-WAIT: drive reset_n=0 asynchronously -> cyc, stb and resp_valid go 0 immediately, req_ready=1. After release, a fresh read completes normally.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: host FSM states, default timeout and the
// peripheral address map used by the slaves and benches.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } wb_state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  localparam logic [31:0] WB_BASE_ADDR     = 32'h3000_0000;
  localparam logic [31:0] WB_RESULT_OFFSET = 32'h0000_0004;
  localparam logic [31:0] WB_RESULT_ADDR   = WB_BASE_ADDR + WB_RESULT_OFFSET;

  // Byte address of the idx-th 32-bit register in the peripheral block.
  function automatic logic [31:0] wb_reg_addr(input int unsigned idx);
    return WB_BASE_ADDR + 32'(idx * 4);
  endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating cycle counter for bounding a bus transfer; expired is raised
// on the last permitted cycle (LIMIT-1). LIMIT of 0 disables expiry.
module wb_timeout_ctr #(
  parameter int LIMIT = 255,
  parameter int TO_W  = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TO_W-1:0] count_reg;
  logic [TO_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en && (count_reg != {TO_W{1'b1}})) begin
      count_next = count_reg + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  generate
    if (LIMIT == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      localparam logic [TO_W-1:0] LAST = TO_W'(LIMIT - 1);
      assign expired = (count_reg == LAST);
    end
  endgenerate

endmodule

// File: rtl/wb_host_master.sv
// Single-outstanding Wishbone pipelined initiator: one valid/ready command
// becomes one bus read or write, answered by a one-cycle response strobe.
module wb_host_master
  import wb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = wb_pkg::DEFAULT_TIMEOUT_CYCLES,
  parameter int TO_W           = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic [DATA_W-1:0] o_wb_data,
  input  logic              i_wb_ack,
  input  logic              i_wb_stall,
  input  logic [DATA_W-1:0] i_wb_data
);

  wb_state_e         state_reg, state_next;
  logic              accept;
  logic              in_xfer;
  logic              complete;
  logic              expired;
  logic              timeout_hit;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              err_reg, err_next;

  assign accept  = (state_reg == ST_IDLE) && req_valid;
  assign in_xfer = (state_reg == ST_REQ) || (state_reg == ST_WAIT);

  // Ack only counts once the strobe has been taken; an ack under stall is
  // a slave protocol violation and is dropped.
  assign complete = ((state_reg == ST_REQ) && i_wb_ack && !i_wb_stall) ||
                    ((state_reg == ST_WAIT) && i_wb_ack);
  assign timeout_hit = in_xfer && expired && !complete;

  wb_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES),
    .TO_W  (TO_W)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (accept),
    .en      (in_xfer),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (req_valid) state_next = ST_REQ;
      ST_REQ: begin
        if (complete || timeout_hit) state_next = ST_RESP;
        else if (!i_wb_stall)        state_next = ST_WAIT;
      end
      ST_WAIT: if (complete || timeout_hit) state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    o_wb_cyc   = 1'b0;
    o_wb_stb   = 1'b0;
    case (state_reg)
      ST_IDLE: req_ready = 1'b1;
      ST_REQ: begin
        o_wb_cyc = 1'b1;
        o_wb_stb = 1'b1;
      end
      ST_WAIT: o_wb_cyc = 1'b1;
      ST_RESP: resp_valid = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  // Response fields change only on entry to RESP and hold until the next one.
  always_comb begin
    rdata_next = rdata_reg;
    err_next   = err_reg;
    if (complete) begin
      rdata_next = we_reg ? '0 : i_wb_data;
      err_next   = 1'b0;
    end else if (timeout_hit) begin
      rdata_next = '0;
      err_next   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        we_reg    <= req_we;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
      end
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
    end
  end

  assign o_wb_we    = we_reg;
  assign o_wb_addr  = addr_reg;
  assign o_wb_data  = wdata_reg;
  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg;

endmodule

// File: tb/tb_wb_host_master.sv
// Directed and randomized transfers against a memory-plus-latency model of
// the bus; prints one line per transfer and a final summary.
module tb_wb_host_master;
  import wb_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic        i_wb_ack = 1'b0;
  logic        i_wb_stall = 1'b0;
  logic [31:0] i_wb_data = '0;

  int vectors = 0;
  int miscompares = 0;
  int txn_no = 0;

  logic [31:0] mem [logic [31:0]];

  wb_host_master #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (TO),
    .TO_W           (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .o_wb_cyc   (o_wb_cyc),
    .o_wb_stb   (o_wb_stb),
    .o_wb_we    (o_wb_we),
    .o_wb_addr  (o_wb_addr),
    .o_wb_data  (o_wb_data),
    .i_wb_ack   (i_wb_ack),
    .i_wb_stall (i_wb_stall),
    .i_wb_data  (i_wb_data)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog observed=stuck expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (32'hDEAD_0000 ^ a);
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after RESP.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int stall_n, input int ack_dly, input bit never_ack,
                         input bit stall_ack);
    int          exp_ack_idx, exp_resp_idx, exp_stb;
    bit          exp_err;
    logic [31:0] exp_rdata;
    int          stall_left, accept_k, resp_idx, stb_cnt, cyc_cnt;
    bit          accepted, acked, done, stable_ok, ready_ok;
    logic        got_err;
    logic [31:0] got_rdata;

    exp_ack_idx = never_ack ? 1000 : stall_n + ack_dly;
    if (exp_ack_idx <= TO - 1) begin
      exp_err = 1'b0;
      exp_resp_idx = exp_ack_idx + 1;
    end else begin
      exp_err = 1'b1;
      exp_resp_idx = TO;
    end
    exp_stb   = (stall_n + 1 < exp_resp_idx) ? stall_n + 1 : exp_resp_idx;
    exp_rdata = (we || exp_err) ? 32'h0 : mem_rd(addr);

    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);

    stall_left = stall_n;
    accepted = 0; acked = 0; done = 0; stable_ok = 1; ready_ok = 1;
    accept_k = 0; resp_idx = -1; stb_cnt = 0; cyc_cnt = 0;
    got_err = 1'bx; got_rdata = 'x;
    for (int k = 0; k < 64 && !done; k++) begin
      if (resp_valid === 1'b1) begin
        resp_idx = k;
        got_err = resp_err;
        got_rdata = resp_rdata;
        done = 1;
      end
      if (req_ready !== 1'b0) ready_ok = 0;
      if (o_wb_cyc === 1'b1) cyc_cnt++;
      if (o_wb_stb === 1'b1) begin
        stb_cnt++;
        if (o_wb_addr !== addr || o_wb_we !== we || (we && o_wb_data !== wdata)) stable_ok = 0;
      end
      // Commands offered while busy must be ignored.
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      req_wdata = $urandom;
      i_wb_ack   = 1'b0;
      i_wb_stall = 1'b0;
      i_wb_data  = $urandom;
      if (o_wb_stb === 1'b1 && !accepted) begin
        if (stall_left > 0) begin
          i_wb_stall = 1'b1;
          stall_left--;
          if (stall_ack) i_wb_ack = 1'b1;
        end else begin
          accepted = 1;
          accept_k = k;
        end
      end
      if (accepted && !acked && !never_ack && o_wb_cyc === 1'b1 && k == accept_k + ack_dly) begin
        i_wb_ack = 1'b1;
        acked = 1;
        if (!we) i_wb_data = mem_rd(addr);
      end
      @(negedge clk);
    end
    i_wb_ack   = 1'b0;
    i_wb_stall = 1'b0;

    if (!done) begin
      chk("resp_seen", 32'd0, 32'd1);
    end else begin
      chk("resp_cycle", 32'(resp_idx), 32'(exp_resp_idx));
      chk("resp_err", 32'(got_err), 32'(exp_err));
      chk("resp_rdata", got_rdata, exp_rdata);
      chk("stb_cycles", 32'(stb_cnt), 32'(exp_stb));
      chk("cyc_cycles", 32'(cyc_cnt), 32'(exp_resp_idx));
      chk("bus_stable", 32'(stable_ok), 32'd1);
      chk("ready_low_busy", 32'(ready_ok), 32'd1);
      chk("resp_one_cycle", 32'(resp_valid), 32'd0);
      chk("ready_after_resp", 32'(req_ready), 32'd1);
      chk("rdata_held", resp_rdata, exp_rdata);
    end
    req_valid = 1'b0;
    if (we && !exp_err) mem[addr] = wdata;
    txn_no++;
    $display("txn %0d we=%0b addr=%h wdata=%h stall=%0d dly=%0d noack=%0b -> resp@%0d err=%0b rdata=%h (exp @%0d err=%0b rdata=%h)",
             txn_no, we, addr, wdata, stall_n, ack_dly, never_ack, resp_idx, got_err, got_rdata,
             exp_resp_idx, exp_err, exp_rdata);
  endtask

  initial begin
    mem[WB_RESULT_ADDR] = 32'h0000_0008;

    #12;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_cyc", 32'(o_wb_cyc), 32'd0);
    chk("rst_stb", 32'(o_wb_stb), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run_txn(1'b1, WB_BASE_ADDR, 32'h0000_0503, 0, 1, 0, 0);
    chk("mem_write_0x503", mem_rd(WB_BASE_ADDR), 32'h0000_0503);
    run_txn(1'b0, WB_RESULT_ADDR, 32'h0, 0, 1, 0, 0);
    run_txn(1'b0, WB_BASE_ADDR, 32'h0, 3, 1, 0, 0);
    run_txn(1'b0, WB_RESULT_ADDR, 32'h0, 0, 0, 1, 0);
    run_txn(1'b0, WB_RESULT_ADDR, 32'h0, 0, TO - 1, 0, 0);
    run_txn(1'b0, WB_RESULT_ADDR, 32'h0, 0, TO, 0, 0);
    run_txn(1'b0, WB_BASE_ADDR, 32'h0, TO - 1, 0, 0, 0);
    run_txn(1'b1, wb_reg_addr(2), 32'hCAFE_F00D, 0, 0, 0, 0);
    run_txn(1'b0, wb_reg_addr(2), 32'h0, 2, 2, 0, 1);
    run_txn(1'b1, wb_reg_addr(3), 32'h1234_5678, TO, 0, 0, 0);

    // Stray ack while idle must not produce a response.
    i_wb_ack  = 1'b1;
    i_wb_data = 32'hBAD0_BAD0;
    repeat (3) begin
      @(negedge clk);
      chk("stray_ack_resp", 32'(resp_valid), 32'd0);
      chk("stray_ack_ready", 32'(req_ready), 32'd1);
    end
    i_wb_ack = 1'b0;
    $display("txn stray-ack-in-idle done");

    // Reset while waiting for ack.
    req_valid = 1'b1; req_we = 1'b0; req_addr = WB_RESULT_ADDR;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("wait_cyc", 32'(o_wb_cyc), 32'd1);
    chk("wait_stb", 32'(o_wb_stb), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_cyc", 32'(o_wb_cyc), 32'd0);
    chk("async_rst_stb", 32'(o_wb_stb), 32'd0);
    chk("async_rst_resp", 32'(resp_valid), 32'd0);
    chk("async_rst_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_no_resp", 32'(resp_valid), 32'd0);
    end
    $display("txn reset-mid-wait done");
    run_txn(1'b0, WB_RESULT_ADDR, 32'h0, 1, 1, 0, 0);

    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom_range(0, 1)), wb_reg_addr($urandom_range(0, 3)), $urandom,
              int'($urandom_range(0, 4)), int'($urandom_range(0, 9)),
              ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
